// File: rtl/mac_accumulator.sv
// Sequential multiply-accumulate neuron stage: bias-seeded, per-step saturating
// sum of N_INPUTS signed a*w products, presented on a valid/ready output.
module mac_accumulator #(
    parameter int N_INPUTS = 16,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ACC_W-1:0]  bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out,
    output logic              sat,
    output logic              busy
);

    localparam int CNT_W = 16;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W:0] MAX_S = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_S = {2'b11, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_OUT
    } state_t;

    state_t state, state_d;

    logic [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]        count;
    logic                    sat_q;
    logic                    accept;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0]        acc_next;
    logic                    clamp;

    assign accept = in_valid && (state == ST_ACCUM);

    // Sum is formed one bit wider than the accumulator so overflow is visible before clamping.
    always_comb begin
        prod     = $signed(a) * $signed(w);
        sum_ext  = $signed({acc[ACC_W-1], acc})
                 + $signed({{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod});
        acc_next = sum_ext[ACC_W-1:0];
        clamp    = 1'b0;
        if (sum_ext > MAX_S) begin
            acc_next = MAX_S[ACC_W-1:0];
            clamp    = 1'b1;
        end else if (sum_ext < MIN_S) begin
            acc_next = MIN_S[ACC_W-1:0];
            clamp    = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (start) state_d = ST_ACCUM;
            ST_ACCUM: if (accept && count == LAST) state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            sat_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc   <= bias;
                        count <= '0;
                        sat_q <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                        if (clamp) sat_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every output is a function of registers only, so nothing on in_* reaches out_* combinationally.
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);
    assign out       = acc;
    assign sat       = sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed test-plan cases plus random
// neurons compared against a plain-arithmetic saturating sum model.
module tb_mac_accumulator;

    logic               clk;
    logic               rst;
    logic               start4, start1;
    logic signed [23:0] bias;
    logic               in_valid;
    logic signed [7:0]  a, w;
    logic               out_ready4, out_ready1;

    logic               in_ready4, out_valid4, sat4, busy4;
    logic signed [23:0] out4;
    logic               in_ready1, out_valid1, sat1, busy1;
    logic signed [23:0] out1;

    int errors = 0;
    int checks = 0;

    mac_accumulator #(.N_INPUTS(4), .DATA_W(8), .ACC_W(24)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready4), .a(a), .w(w),
        .out_valid(out_valid4), .out_ready(out_ready4), .out(out4),
        .sat(sat4), .busy(busy4)
    );

    mac_accumulator #(.N_INPUTS(1), .DATA_W(8), .ACC_W(24)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready1), .a(a), .w(w),
        .out_valid(out_valid1), .out_ready(out_ready1), .out(out1),
        .sat(sat1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: bias plus products, clamped to the 24-bit signed range after every step.
    function automatic void model(input int b, input int av[4], input int wv[4],
                                  output int sum, output int sflag);
        longint acc;
        acc   = b;
        sflag = 0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + longint'(av[i]) * longint'(wv[i]);
            if (acc > 64'sd8388607) begin
                acc = 8388607; sflag = 1;
            end else if (acc < -64'sd8388608) begin
                acc = -8388608; sflag = 1;
            end
        end
        sum = int'(acc);
    endfunction

    task automatic apply_stimulus(input int b, input int av[4], input int wv[4],
                                  input bit gaps, input int stall, input bit stray);
        int exp_sum, exp_sat, g;
        model(b, av, wv, exp_sum, exp_sat);
        bias = 24'(b); start4 = 1'b1; in_valid = 1'b0; out_ready4 = 1'b0;
        step();
        start4 = 1'b0;
        check_output("busy_accum", busy4, 1);
        check_output("in_ready_accum", in_ready4, 1);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    in_valid = 1'b0; a = 8'($urandom); w = 8'($urandom); start4 = stray;
                    step();
                    start4 = 1'b0;
                end
            end
            in_valid = 1'b1; a = 8'(av[i]); w = 8'(wv[i]); start4 = stray;
            step();
            start4 = 1'b0; in_valid = 1'b0;
            if (i < 3) check_output("out_valid_early", out_valid4, 0);
        end
        check_output("out_valid_rise", out_valid4, 1);
        check_output("out_value", out4, exp_sum);
        check_output("sat_value", sat4, exp_sat);
        check_output("in_ready_out", in_ready4, 0);
        for (int k = 0; k < stall; k++) begin
            out_ready4 = 1'b0; in_valid = 1'b1; a = 8'sd5; w = 8'sd5; start4 = stray;
            step();
            start4 = 1'b0;
            check_output("stall_valid", out_valid4, 1);
            check_output("stall_out", out4, exp_sum);
            check_output("stall_sat", sat4, exp_sat);
            check_output("stall_in_ready", in_ready4, 0);
        end
        in_valid = 1'b0; out_ready4 = 1'b1; start4 = stray;
        step();
        start4 = 1'b0; out_ready4 = 1'b0;
        check_output("out_valid_drop", out_valid4, 0);
        check_output("idle_after_out", busy4, 0);
        step();
        check_output("stray_start_ignored", busy4, 0);
    endtask

    initial begin
        int av[4], wv[4];
        int b;
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; bias = '0; in_valid = 1'b1;
        a = 8'sd3; w = 8'sd3; out_ready4 = 1'b0; out_ready1 = 1'b0;
        step(); step();
        rst = 1'b0;
        check_output("rst_in_ready", in_ready4, 0);
        check_output("rst_out_valid", out_valid4, 0);
        check_output("rst_busy", busy4, 0);
        check_output("rst_sat", sat4, 0);
        check_output("rst_out", out4, 0);
        step();
        check_output("idle_no_consume", in_ready4, 0);
        check_output("idle_busy", busy4, 0);
        in_valid = 1'b0;

        // Basic sum: 100 + 100 - 100 + 16129 + 16384 = 32613
        av = '{10, -5, 127, -128}; wv = '{10, 20, 127, -128};
        apply_stimulus(100, av, wv, 1'b0, 0, 1'b0);
        check_output("basic_literal", out4, 32613);

        // Positive rail then recovery
        av = '{127, -128, 0, 0}; wv = '{127, 127, 0, 0};
        apply_stimulus(8388000, av, wv, 1'b0, 0, 1'b0);
        check_output("possat_literal", out4, 8372351);
        check_output("possat_flag", sat4, 1);

        // Negative rail
        av = '{-128, -128, -128, -128}; wv = '{127, 127, 127, 127};
        apply_stimulus(-8388000, av, wv, 1'b0, 0, 1'b0);
        check_output("negsat_literal", out4, -8388608);

        // Bubbles, output stall and stray starts
        av = '{10, -5, 127, -128}; wv = '{10, 20, 127, -128};
        apply_stimulus(100, av, wv, 1'b1, 5, 1'b1);
        check_output("stall_literal", out4, 32613);

        // Reset after two accepted pairs
        bias = 24'sd777; start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 8'sd100; w = 8'sd100;
            step();
        end
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("midrst_busy", busy4, 0);
        check_output("midrst_out_valid", out_valid4, 0);
        check_output("midrst_out", out4, 0);
        check_output("midrst_sat", sat4, 0);
        av = '{1, 1, 1, 1}; wv = '{1, 1, 1, 1};
        apply_stimulus(0, av, wv, 1'b0, 0, 1'b0);
        check_output("post_rst_sum", out4, 4);

        // Single-input build
        bias = -24'sd5; start1 = 1'b1;
        step();
        start1 = 1'b0;
        check_output("n1_in_ready", in_ready1, 1);
        in_valid = 1'b1; a = 8'sd3; w = -8'sd2;
        step();
        in_valid = 1'b0;
        check_output("n1_out_valid", out_valid1, 1);
        check_output("n1_out", out1, -11);
        check_output("n1_sat", sat1, 0);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check_output("n1_idle", busy1, 0);

        // Random neurons, biases biased toward the rails to exercise clamping
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0:       b = int'($urandom_range(0, 4000)) - 2000;
                1:       b = 8388607 - int'($urandom_range(0, 40000));
                default: b = -8388608 + int'($urandom_range(0, 40000));
            endcase
            for (int i = 0; i < 4; i++) begin
                av[i] = int'($urandom_range(0, 255)) - 128;
                wv[i] = int'($urandom_range(0, 255)) - 128;
            end
            apply_stimulus(b, av, wv, 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
